// File: rtl/master_bridge_fifo_reader.sv
// Read-domain consumer of the master bridge async FIFO: pops words into a
// 2-entry skid buffer and frames them into header/data packets on a valid/ready stream.
module master_bridge_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int LEN_LSB    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_inc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_in_pkt
);

  typedef enum logic {ST_HDR, ST_DATA} state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [LEN_WIDTH-1:0]  w_remNext;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_pushFirst;
  logic                  w_pushLast;

  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_first0;
  logic                  r_first1;
  logic                  r_last0;
  logic                  r_last1;

  logic                  w_push;
  logic                  w_accept;

  // Popping depends only on buffer occupancy, never on i_ready, so the FIFO
  // handshake has no combinational path from the downstream consumer.
  assign w_push   = !i_rst && !i_fifo_empty && (r_count != 2'd2);
  assign w_accept = o_valid && i_ready;

  assign o_fifo_inc = w_push;
  assign o_valid    = (r_count != 2'd0);
  assign o_data     = r_data0;
  assign o_first    = r_first0 && o_valid;
  assign o_last     = r_last0 && o_valid;
  assign o_in_pkt   = (r_state == ST_DATA);

  assign w_len = i_fifo_data[LEN_LSB +: LEN_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HDR;
      r_rem   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_rem   <= w_remNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_remNext   = r_rem;
    w_pushFirst = 1'b0;
    w_pushLast  = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_pushFirst = 1'b1;
        w_pushLast  = (w_len == '0);
        if (w_push && (w_len != '0)) begin
          w_remNext   = w_len;
          w_stateNext = ST_DATA;
        end
      end
      ST_DATA: begin
        w_pushLast = (r_rem == LEN_WIDTH'(1));
        if (w_push) begin
          w_remNext = r_rem - LEN_WIDTH'(1);
          if (r_rem == LEN_WIDTH'(1)) w_stateNext = ST_HDR;
        end
      end
      default: w_stateNext = ST_HDR;
    endcase
  end

  // Entry 0 is the head; entry 1 is the skid slot that shifts forward on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= 2'd0;
      r_data0  <= '0;
      r_data1  <= '0;
      r_first0 <= 1'b0;
      r_first1 <= 1'b0;
      r_last0  <= 1'b0;
      r_last1  <= 1'b0;
    end else begin
      case ({w_push, w_accept})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0  <= i_fifo_data;
            r_first0 <= w_pushFirst;
            r_last0  <= w_pushLast;
          end else begin
            r_data1  <= i_fifo_data;
            r_first1 <= w_pushFirst;
            r_last1  <= w_pushLast;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0  <= r_data1;
          r_first0 <= r_first1;
          r_last0  <= r_last1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_data0  <= i_fifo_data;
            r_first0 <= w_pushFirst;
            r_last0  <= w_pushLast;
          end else begin
            r_data0  <= r_data1;
            r_first0 <= r_first1;
            r_last0  <= r_last1;
            r_data1  <= i_fifo_data;
            r_first1 <= w_pushFirst;
            r_last1  <= w_pushLast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
